lifo_arbiter: RTL
=================

// Module: lifo_arbiter
// PURPOSE
//  Round-robin front end that shares one LIFO stack between NUM_REQ requesters.
//  Each requester issues push/pop commands over a valid/ready handshake. The block drives the stack's
//  wr_en/rd_en/data_wr ports and returns per-command responses with popped data or an error.
//  Sits between client engines and a single lifo instance. Never issues simultaneous push+pop (no bypass).
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  DATA_WIDTH  8   stack word width
//  DEPTH       12  stack depth; sizes occupancy counter CNT_W = clog2(DEPTH+1)
// PORTS
//  clk           in   1              clock, all logic on posedge
//  rst_n         in   1              synchronous active-low reset
//  req_valid     in   NUM_REQ        per-requester command valid
//  req_op        in   NUM_REQ        per-requester op: 1=push, 0=pop
//  req_data      in   NUM_REQ*DATA_W push data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready     out  NUM_REQ        one-hot grant; transfer when req_valid[i]&req_ready[i]
//  rsp_valid     out  NUM_REQ        one-hot response strobe, 1 cycle
//  rsp_err       out  1              response is error (push when full / pop when empty)
//  rsp_data      out  DATA_WIDTH     popped word; 0 for push or error responses
//  lifo_wr_en    out  1              push strobe to stack
//  lifo_rd_en    out  1              pop strobe to stack
//  lifo_data_wr  out  DATA_WIDTH     push data to stack
//  lifo_data_rd  in   DATA_WIDTH     stack read data, valid the cycle after lifo_rd_en
//  lifo_full     in   1              stack full flag
//  lifo_empty    in   1              stack empty flag
//  occupancy     out  CNT_W          words held, mirrored from issued ops
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): rr pointer=0 (req 0 highest priority), rsp_valid=0, rsp_err=0, occupancy=0.
//   Outputs rsp_data/lifo_wr_en/lifo_rd_en read 0 during and after reset until a command is accepted.
//   A pop accepted the cycle before reset gives no response; stack reset is handled by the system.
//  Arbitration: combinational; at most one req_ready bit high per cycle, only to a requester with valid=1.
//   Search starts at rr pointer, wraps modulo NUM_REQ. On acceptance, rr pointer <= granted index + 1 (wrap).
//   req_ready=0 for all requesters during reset and when no valid.
//  Issue (same cycle as acceptance, combinational from grant):
//   push & !lifo_full  -> lifo_wr_en=1, lifo_data_wr=req_data[granted]; occupancy+1 at edge.
//   pop  & !lifo_empty -> lifo_rd_en=1; occupancy-1 at edge.
//   push &  lifo_full or pop & lifo_empty -> no stack strobe; error response; occupancy unchanged.
//   lifo_wr_en and lifo_rd_en never both 1. lifo_data_wr=0 when lifo_wr_en=0.
//  Response: exactly 1 cycle after acceptance (registered requester id, op, err).
//   rsp_valid[id]=1; rsp_err per issue decision.
//   rsp_data=lifo_data_rd for a successful pop, else 0.
//  Throughput: one command per cycle, back-to-back allowed. Flags sampled each cycle reflect all prior issues.
//  Requesters hold valid/op/data stable until ready. Deasserting valid before ready is allowed; grant moves on.
//  occupancy saturates at 0..DEPTH; it must equal the stack count at all times (assertion target).
// TESTING
//  1 reset: rst_n=0 2 cycles with all valid=1 -> req_ready=0, rsp_valid=0, occupancy=0.
//  2 single: req1 push 0xA5, then req1 pop -> lifo_wr_en 1 cycle, then rsp_valid=4'b0010, err=0,
//    rsp_data=0xA5; occupancy 1 then 0.
//  3 fairness: all 4 valid pushing continuously -> grants 0,1,2,3,0,... ; no requester is granted twice
//    before all others are served.
//  4 empty: pop at reset -> no lifo_rd_en; next cycle rsp_err=1, rsp_data=0.
//  5 full: DEPTH=12, 12 pushes 0x01..0x0C then push 0xFF -> 13th gives rsp_err=1, no lifo_wr_en;
//    then 12 pops return 0x0C..0x01 in order; occupancy back to 0.
//  6 interleave/reset: req0 push, req2 pop back-to-back, with rst_n=0 asserted in the cycle after the pop
//    is accepted -> no rsp_valid; post-reset grant restarts at req 0.

Source files
------------

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: round-robin front end sharing one LIFO stack between NUM_REQ requesters.
//
// Handshake: a command transfers in the cycle where req_valid[i] & req_ready[i] are both 1.
// req_ready is a combinational one-hot grant and is only ever raised for a requester whose
// req_valid is already 1. Requesters keep op/data stable while valid and not ready. Dropping
// valid before ready is allowed; the grant simply moves on. Every accepted command gets exactly
// one rsp_valid strobe in the following cycle, unless reset is asserted in that cycle.
module lifo_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 12,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          lifo_wr_en,
  output logic                          lifo_rd_en,
  output logic [DATA_WIDTH-1:0]         lifo_data_wr,
  input  logic [DATA_WIDTH-1:0]         lifo_data_rd,
  input  logic                          lifo_full,
  input  logic                          lifo_empty,
  output logic [CNT_W-1:0]              occupancy
);

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_found;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_op;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  issue_err;
  logic [IDX_W-1:0]      rr_next;

  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic                  rsp_err_q;
  logic                  rsp_pop_q;
  logic [CNT_W-1:0]      occ_q;

  // Round-robin search starting at rr_ptr; no grant while reset is held.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant_found && rst_n && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  // Issue decision for the granted command, same cycle as acceptance.
  always_comb begin
    grant_op   = req_op[grant_idx];
    grant_data = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    push_ok    = grant_found &&  grant_op && !lifo_full;
    pop_ok     = grant_found && !grant_op && !lifo_empty;
    issue_err  = grant_found && ((grant_op && lifo_full) || (!grant_op && lifo_empty));
    rr_next    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign req_ready    = grant;
  assign lifo_wr_en   = push_ok;
  assign lifo_rd_en   = pop_ok;
  assign lifo_data_wr = push_ok ? grant_data : '0;

  // Round-robin pointer advances past the requester just served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_found) begin
      rr_ptr <= rr_next;
    end
  end

  // Occupancy mirror of the stack, tracked from issued strobes, clamped to 0..DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (push_ok && (occ_q != CNT_W'(DEPTH))) begin
      occ_q <= occ_q + 1'b1;
    end else if (pop_ok && (occ_q != '0)) begin
      occ_q <= occ_q - 1'b1;
    end
  end

  assign occupancy = occ_q;

  // Registered response context: who was served, whether it failed, whether data comes back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_pop_q   <= 1'b0;
    end else begin
      rsp_valid_q <= grant;
      rsp_err_q   <= issue_err;
      rsp_pop_q   <= pop_ok;
    end
  end

  // Responses are masked while reset is low so a command accepted just before reset is dropped.
  assign rsp_valid = rst_n ? rsp_valid_q : '0;
  assign rsp_err   = rst_n & rsp_err_q;
  assign rsp_data  = (rst_n && rsp_pop_q) ? lifo_data_rd : '0;

endmodule
